// File: rtl/or3_gate.sv
`default_nettype none
// ============================================================================
//  Module   : or3_gate
//  Purpose  : Bitwise three-input OR with a small registered observation
//             block (synchronised copy, rising-edge pulse, saturating
//             high-cycle counter).
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH   number of independent OR lanes
//    CNT_W   width of the high-cycle counter
//  Ports
//    clk      in   1      rising-edge clock for all registers
//    rst_n    in   1      asynchronous active-low reset
//    a,b,c    in   WIDTH  OR operands
//    cnt_clr  in   1      synchronous clear of hi_cnt (wins over increment)
//    y        out  WIDTH  combinational a | b | c, valid during reset
//    y_q      out  WIDTH  y delayed by one clock
//    y_rise   out  WIDTH  one-cycle pulse per lane when y_q goes 0->1
//    hi_cnt   out  CNT_W  saturating count of cycles with any lane of y high
// ============================================================================
module or3_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic [WIDTH-1:0] y_rise,
  output logic [CNT_W-1:0] hi_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  // Previous value of y_q, used only for edge detection.
  logic [WIDTH-1:0] r_y_q_d;
  logic             w_any_hi;
  logic             w_cnt_inc;

  // Primary function: no dependence on clk or rst_n.
  assign y = a | b | c;

  assign w_any_hi  = |y;
  // Counter stops at all-ones rather than wrapping.
  assign w_cnt_inc = w_any_hi && (hi_cnt != c_cnt_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      r_y_q_d <= '0;
      hi_cnt  <= '0;
    end else begin
      y_q     <= y;
      r_y_q_d <= y_q;
      if (cnt_clr) begin
        hi_cnt <= '0;
      end else if (w_cnt_inc) begin
        hi_cnt <= hi_cnt + c_cnt_one;
      end
    end
  end

  // Both terms come from registers, so the pulse is glitch-free and exactly
  // one cycle wide. A lane held high across reset release pulses once,
  // because r_y_q_d trails y_q by one edge.
  assign y_rise = y_q & ~r_y_q_d;

endmodule
`default_nettype wire

// File: tb/tb_or3_gate.sv
`default_nettype none
// ============================================================================
//  Module   : tb_or3_gate
//  Purpose  : Self-checking bench for or3_gate. A 4-lane/16-bit instance and
//             a 1-lane/3-bit instance (driven from lane 0) share stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_or3_gate;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a, b, c;
  logic         cnt_clr;
  logic [W-1:0] y, y_q, y_rise;
  logic [15:0]  hi_cnt;
  logic         s_y, s_y_q, s_y_rise;
  logic [2:0]   s_hi_cnt;

  int checks   = 0;
  int failures = 0;

  // Behavioural reference: last two sampled y values and plain integer counts.
  logic [W-1:0] m_yq, m_yq_prev;
  int           m_cnt, m_cnt_sat;

  or3_gate #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .cnt_clr(cnt_clr),
    .y(y), .y_q(y_q), .y_rise(y_rise), .hi_cnt(hi_cnt)
  );

  or3_gate #(.WIDTH(1), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .a(a[0]), .b(b[0]), .c(c[0]), .cnt_clr(cnt_clr),
    .y(s_y), .y_q(s_y_q), .y_rise(s_y_rise), .hi_cnt(s_hi_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] y;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_yq      = '0;
    m_yq_prev = '0;
    m_cnt     = 0;
    m_cnt_sat = 0;
  endtask

  // Advance the model with the inputs the DUT is about to sample, then move
  // to 1 time unit past the rising edge.
  task automatic tick();
    logic [W-1:0] yn;
    if (rst_n) begin
      yn        = a | b | c;
      m_yq_prev = m_yq;
      m_yq      = yn;
      if (cnt_clr) begin
        m_cnt     = 0;
        m_cnt_sat = 0;
      end else begin
        if (yn != 0)  m_cnt     = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
        if (yn[0])    m_cnt_sat = (m_cnt_sat + 1 > 7) ? 7 : m_cnt_sat + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [W-1:0] rise;
    rise = m_yq & ~m_yq_prev;
    chk({tag, ".y"},          32'(y),        32'(a | b | c));
    chk({tag, ".y_q"},        32'(y_q),      32'(m_yq));
    chk({tag, ".y_rise"},     32'(y_rise),   32'(rise));
    chk({tag, ".hi_cnt"},     32'(hi_cnt),   32'(m_cnt));
    chk({tag, ".sat_y_q"},    32'(s_y_q),    32'(m_yq[0]));
    chk({tag, ".sat_rise"},   32'(s_y_rise), 32'(rise[0]));
    chk({tag, ".sat_hi_cnt"}, 32'(s_hi_cnt), 32'(m_cnt_sat));
  endtask

  // Asynchronous reset pulse starting between edges; ends 1 unit past an edge.
  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst.hi_cnt", 32'(hi_cnt), 32'd0);
    chk("async_rst.y_q",    32'(y_q),    32'd0);
    tick();
    rst_n = 1'b1;
  endtask

  vec_t tv[10];
  int   pulses;
  logic prev_rise;

  initial begin
    rst_n = 1'b0; a = '0; b = '0; c = '0; cnt_clr = 1'b0;
    model_reset();

    // ---------------- truth table, no clock edge needed -----------------
    tv[0] = '{4'h0, 4'h0, 4'h0, 4'h0};
    tv[1] = '{4'hF, 4'h0, 4'h0, 4'hF};
    tv[2] = '{4'h0, 4'hF, 4'h0, 4'hF};
    tv[3] = '{4'hF, 4'hF, 4'h0, 4'hF};
    tv[4] = '{4'h0, 4'h0, 4'hF, 4'hF};
    tv[5] = '{4'hF, 4'h0, 4'hF, 4'hF};
    tv[6] = '{4'h0, 4'hF, 4'hF, 4'hF};
    tv[7] = '{4'hF, 4'hF, 4'hF, 4'hF};
    tv[8] = '{4'h1, 4'h4, 4'h0, 4'h5};
    tv[9] = '{4'h0, 4'h2, 4'h2, 4'h2};
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      a = tv[i].a; b = tv[i].b; c = tv[i].c;
      #1;
      chk($sformatf("truth[%0d].y", i), 32'(y), 32'(tv[i].y));
      chk($sformatf("truth[%0d].sat_y", i), 32'(s_y), 32'(tv[i].y[0]));
    end

    // ---------------- reset hold with a=1, then release ------------------
    a = 4'hF; b = '0; c = '0;
    tick(); tick();
    chk("rst_hold.y",      32'(y),      32'hF);
    chk("rst_hold.y_q",    32'(y_q),    32'h0);
    chk("rst_hold.y_rise", 32'(y_rise), 32'h0);
    chk("rst_hold.hi_cnt", 32'(hi_cnt), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_rel1.y_q",    32'(y_q),    32'hF);
    chk("rst_rel1.y_rise", 32'(y_rise), 32'hF);
    chk("rst_rel1.hi_cnt", 32'(hi_cnt), 32'd1);
    tick();
    chk("rst_rel2.y_rise", 32'(y_rise), 32'h0);
    chk("rst_rel2.hi_cnt", 32'(hi_cnt), 32'd2);
    check_model("rst_rel2");

    // ---------------- edge detect: 0,1,0,1 in 2-cycle intervals ----------
    a = '0;
    pulse_reset();
    pulses = 0; prev_rise = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a = ((i / 2) % 2 == 1) ? 4'h1 : 4'h0;
      tick();
      check_model($sformatf("edge[%0d]", i));
      if (y_rise[0]) begin
        pulses++;
        chk("edge.pulse_width", 32'(prev_rise), 32'd0);
      end
      prev_rise = y_rise[0];
    end
    chk("edge.pulse_count", 32'(pulses), 32'd2);

    // ---------------- counter: 5 high, 3 low, clear ----------------------
    a = '0;
    pulse_reset();
    a = 4'h1;
    for (int i = 0; i < 5; i++) tick();
    a = '0;
    for (int i = 0; i < 3; i++) tick();
    chk("cnt.hold5",     32'(hi_cnt),   32'd5);
    chk("cnt.sat_hold5", 32'(s_hi_cnt), 32'd5);
    a = 4'h1; cnt_clr = 1'b1;
    tick();
    chk("cnt.clr_wins", 32'(hi_cnt), 32'd0);
    cnt_clr = 1'b0;
    tick();
    chk("cnt.after_clr", 32'(hi_cnt), 32'd1);

    // ---------------- saturation on the 3-bit instance -------------------
    a = '0;
    pulse_reset();
    a = 4'h1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("sat[%0d]", i), 32'(s_hi_cnt), (i + 1 > 7) ? 32'd7 : 32'(i + 1));
    end
    chk("sat.main_cnt", 32'(hi_cnt), 32'd10);

    // ---------------- async reset mid-count ------------------------------
    a = '0;
    pulse_reset();
    a = 4'h1;
    for (int i = 0; i < 4; i++) tick();
    chk("midrst.pre", 32'(hi_cnt), 32'd4);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst.hi_cnt",     32'(hi_cnt),   32'd0);
    chk("midrst.sat_hi_cnt", 32'(s_hi_cnt), 32'd0);
    chk("midrst.y_q",        32'(y_q),      32'd0);
    chk("midrst.y",          32'(y),        32'h1);
    tick();
    rst_n = 1'b1;

    // ---------------- randomized run against the model -------------------
    for (int i = 0; i < 400; i++) begin
      a = 4'($urandom & $urandom & $urandom);
      b = 4'($urandom & $urandom & $urandom);
      c = 4'($urandom & $urandom & $urandom);
      cnt_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 59) == 0) begin
        pulse_reset();
      end else begin
        tick();
      end
      check_model($sformatf("rand[%0d]", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
